// File: rtl/serial_adder_16b.sv
// Bit-serial WIDTH-bit adder (a + b + cin) built around a single full_adder cell.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf_out.

// full_adder: one-bit sum/carry cell.
// Latency: combinational.
// Backpressure: none.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

// serial_adder_16b: LSB-first serial add, one bit per clock.
// Latency: result valid WIDTH+1 edges after the accepting edge, counting that edge.
// Backpressure: holds the result in DONE until out_ready; in_ready low while busy.
module serial_adder_16b #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             fa_sum;
  logic             fa_carry;
  logic             cnt_last;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  full_adder u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign cnt_d    = cnt_q + CW'(1);
  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a_in;
            b_q        <= b_in;
            carry_q    <= c_in;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= {fa_sum, res_q[WIDTH-1:1]};
          carry_q <= fa_carry;
          // Counter parks at WIDTH-1 on the last bit so it never wraps.
          if (cnt_last) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= carry_q ^ fa_carry;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum_out   = res_q;
  assign carry_out = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf_out   = ovf_q;
`endif

endmodule
